// File: rtl/muldiv_scheduler_pkg.sv
// Shared types for the two-lane iterative multiply/divide unit.
package muldiv_scheduler_pkg;
   localparam int DWIDTH = 32;

   typedef enum logic [1:0] {
      MD_OP_MULT  = 2'b00,
      MD_OP_MULTU = 2'b01,
      MD_OP_DIV   = 2'b10,
      MD_OP_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MD_ST_IDLE = 2'b00,
      MD_ST_RUN  = 2'b01,
      MD_ST_DONE = 2'b10
   } md_st_e;

   function automatic logic op_signed(md_op_e op);
      return (op == MD_OP_MULT) || (op == MD_OP_DIV);
   endfunction

   function automatic logic op_div(md_op_e op);
      return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   endfunction
endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiply / restoring divide on operand
// magnitudes, with combinational sign fix-up of the final accumulator.
module muldiv_core
   import muldiv_scheduler_pkg::*;
#(
   parameter int WIDTH = DWIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             step,
   input  md_op_e           op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic [WIDTH-1:0] hi_res,
   output logic [WIDTH-1:0] lo_res
);
   function automatic logic [WIDTH-1:0] mag(logic [WIDTH-1:0] v, logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   logic             sgn, is_div;
   logic [WIDTH-1:0] rs_mag, rt_mag;
   logic [WIDTH-1:0] hi_q, lo_q, hi_in, lo_in;
   logic [WIDTH:0]   sum, shl, diff;
   logic             ge;
   logic [2*WIDTH-1:0] prod, prod_fix;

   assign sgn    = op_signed(op);
   assign is_div = op_div(op);
   assign rs_mag = mag(rs, sgn);
   assign rt_mag = mag(rt, sgn);

   // The first iteration works from a cleared accumulator, so no separate load cycle.
   assign hi_in = start ? '0 : hi_q;
   assign lo_in = start ? (is_div ? rs_mag : rt_mag) : lo_q;

   assign sum  = {1'b0, hi_in} + (lo_in[0] ? {1'b0, rs_mag} : '0);
   assign shl  = {hi_in, lo_in[WIDTH-1]};
   assign diff = shl - {1'b0, rt_mag};
   assign ge   = ~diff[WIDTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (step) begin
         if (is_div) begin
            hi_q <= ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
            lo_q <= {lo_in[WIDTH-2:0], ge};
         end else begin
            hi_q <= sum[WIDTH:1];
            lo_q <= {sum[0], lo_in[WIDTH-1:1]};
         end
      end
   end

   assign prod     = {hi_q, lo_q};
   assign prod_fix = (sgn && (rs[WIDTH-1] ^ rt[WIDTH-1])) ? -prod : prod;

   always_comb begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
      if (is_div) begin
         if (rt == '0) begin
            hi_res = rs;
            lo_res = '1;
         end else begin
            lo_res = (sgn && (rs[WIDTH-1] ^ rt[WIDTH-1])) ? -lo_q : lo_q;
            hi_res = (sgn && rs[WIDTH-1]) ? -hi_q : hi_q;
         end
      end
   end
endmodule

// File: rtl/muldiv_scheduler.sv
// Two-lane arbiter and sequencer for the shared multiply/divide unit; owns HI/LO.
module muldiv_scheduler
   import muldiv_scheduler_pkg::*;
#(
   parameter int WIDTH = DWIDTH,
   parameter int CNT_W = 6
) (
   input  logic             md_i_clk,
   input  logic             md_i_rst,
   input  logic             md_i_req0,
   input  logic             md_i_req1,
   input  logic [1:0]       md_i_op0,
   input  logic [1:0]       md_i_op1,
   input  logic [WIDTH-1:0] md_i_rs0,
   input  logic [WIDTH-1:0] md_i_rt0,
   input  logic [WIDTH-1:0] md_i_rs1,
   input  logic [WIDTH-1:0] md_i_rt1,
   input  logic             md_i_flush,
   output logic             md_o_ack0,
   output logic             md_o_ack1,
   output logic             md_o_stall0,
   output logic             md_o_stall1,
   output logic             md_o_busy,
   output logic             md_o_hilo_valid,
   output logic [WIDTH-1:0] md_o_hi,
   output logic [WIDTH-1:0] md_o_lo
);
   md_st_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             grant_q, grant, start, step, done_ok;
   md_op_e           op_q;
   logic [WIDTH-1:0] rs_q, rt_q, hi_res, lo_res;

   always_ff @(posedge md_i_clk) begin
      if (!md_i_rst) state_q <= MD_ST_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      start   = 1'b0;
      step    = 1'b0;
      case (state_q)
         MD_ST_IDLE: if (md_i_req0 || md_i_req1) begin
            grant   = 1'b1;
            state_d = MD_ST_RUN;
         end
         MD_ST_RUN: begin
            step  = 1'b1;
            start = (cnt_q == '0);
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = MD_ST_DONE;
         end
         MD_ST_DONE: state_d = MD_ST_IDLE;
         default:    state_d = MD_ST_IDLE;
      endcase
      // Squash overrides everything, including a grant pending in IDLE.
      if (md_i_flush) begin
         state_d = MD_ST_IDLE;
         grant   = 1'b0;
      end
   end

   always_ff @(posedge md_i_clk) begin
      if (!md_i_rst) begin
         cnt_q   <= '0;
         grant_q <= 1'b0;
         op_q    <= MD_OP_MULT;
         rs_q    <= '0;
         rt_q    <= '0;
         md_o_hi <= '0;
         md_o_lo <= '0;
      end else begin
         cnt_q <= (state_q == MD_ST_RUN && state_d == MD_ST_RUN) ? cnt_q + CNT_W'(1) : '0;
         if (grant) begin
            grant_q <= ~md_i_req0;
            op_q    <= md_op_e'(md_i_req0 ? md_i_op0 : md_i_op1);
            rs_q    <= md_i_req0 ? md_i_rs0 : md_i_rs1;
            rt_q    <= md_i_req0 ? md_i_rt0 : md_i_rt1;
         end
         if (done_ok) begin
            md_o_hi <= hi_res;
            md_o_lo <= lo_res;
         end
      end
   end

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk    (md_i_clk),
      .rst_n  (md_i_rst),
      .start  (start),
      .step   (step),
      .op     (op_q),
      .rs     (rs_q),
      .rt     (rt_q),
      .hi_res (hi_res),
      .lo_res (lo_res)
   );

   assign done_ok         = (state_q == MD_ST_DONE) && !md_i_flush;
   assign md_o_ack0       = done_ok && !grant_q;
   assign md_o_ack1       = done_ok &&  grant_q;
   assign md_o_stall0     = md_i_req0 & ~md_o_ack0;
   assign md_o_stall1     = md_i_req1 & ~md_o_ack1;
   assign md_o_busy       = (state_q != MD_ST_IDLE);
   assign md_o_hilo_valid = ~md_o_busy & ~md_i_req0 & ~md_i_req1;
endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench: table of single-op vectors plus arbitration/flush/reset sequences.
module tb_muldiv_scheduler;
   import muldiv_scheduler_pkg::*;

   logic        clk = 1'b0, rst = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, flush = 1'b0;
   logic [1:0]  op0 = '0, op1 = '0;
   logic [31:0] rs0 = '0, rt0 = '0, rs1 = '0, rt1 = '0;
   logic        ack0, ack1, stall0, stall1, busy, hilo_valid;
   logic [31:0] hi, lo;

   int n_checks = 0, n_errors = 0;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] rs, rt, exp_hi, exp_lo;
   } vec_t;
   vec_t vecs[12];

   always #5 clk = ~clk;

   muldiv_scheduler dut (
      .md_i_clk(clk), .md_i_rst(rst),
      .md_i_req0(req0), .md_i_req1(req1),
      .md_i_op0(op0), .md_i_op1(op1),
      .md_i_rs0(rs0), .md_i_rt0(rt0), .md_i_rs1(rs1), .md_i_rt1(rt1),
      .md_i_flush(flush),
      .md_o_ack0(ack0), .md_o_ack1(ack1),
      .md_o_stall0(stall0), .md_o_stall1(stall1),
      .md_o_busy(busy), .md_o_hilo_valid(hilo_valid),
      .md_o_hi(hi), .md_o_lo(lo)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue on one lane, return cycles from the request cycle to its ack (100 = timeout).
   task automatic run_op(input int lane, input logic [1:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, output int n);
      if (lane == 0) begin req0 = 1'b1; op0 = op; rs0 = rs; rt0 = rt; end
      else           begin req1 = 1'b1; op1 = op; rs1 = rs; rt1 = rt; end
      n = 0;
      while (n < 100) begin
         cyc();
         n++;
         if ((lane == 0) ? ack0 : ack1) break;
      end
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin
      int n, a0, a1;
      logic stall_ok, seen;

      vecs[0]  = '{MD_OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1]  = '{MD_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[2]  = '{MD_OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
      vecs[3]  = '{MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
      vecs[4]  = '{MD_OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
      vecs[5]  = '{MD_OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
      vecs[6]  = '{MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[7]  = '{MD_OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[8]  = '{MD_OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};
      vecs[9]  = '{MD_OP_MULT,  32'h80000000, 32'd2,        32'hFFFFFFFF, 32'd0};
      vecs[10] = '{MD_OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[11] = '{MD_OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};

      // Reset
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_hilo_valid", hilo_valid, 1);

      // Single-op vectors, alternating lanes
      for (int i = 0; i < 12; i++) begin
         run_op(i % 2, vecs[i].op, vecs[i].rs, vecs[i].rt, n);
         check($sformatf("vec%0d_ack_cycle", i), n, 33);
         cyc();
         check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
         check($sformatf("vec%0d_hilo_valid", i), hilo_valid, 1);
      end

      // Both lanes in the same cycle: lane 0 first, lane 1 on the following IDLE
      req0 = 1'b1; op0 = MD_OP_DIVU;  rs0 = 32'd100;   rt0 = 32'd7;
      req1 = 1'b1; op1 = MD_OP_MULTU; rs1 = 32'h10000; rt1 = 32'h10000;
      #1;
      check("both_stall0_c0", stall0, 1);
      stall_ok = stall1;
      a0 = -1; a1 = -1;
      for (int c = 1; c <= 80; c++) begin
         cyc();
         if (c <= 66 && !stall1) stall_ok = 1'b0;
         if (c == 34) check("both_lane0_hilo", {hi, lo}, {32'd2, 32'd14});
         if (ack0) begin a0 = c; req0 = 1'b0; end
         if (ack1) begin a1 = c; req1 = 1'b0; break; end
      end
      req0 = 1'b0; req1 = 1'b0;
      check("both_ack0_cycle", a0, 33);
      check("both_ack1_cycle", a1, 67);
      check("both_stall1_held", stall_ok, 1);
      cyc();
      check("both_lane1_hilo", {hi, lo}, {32'd1, 32'd0});

      // Flush mid-MULT at cycle 10
      req0 = 1'b1; op0 = MD_OP_MULT; rs0 = 32'd3; rt0 = 32'd5;
      seen = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         cyc();
         seen |= ack0 | ack1;
      end
      flush = 1'b1;
      cyc();
      seen |= ack0 | ack1;
      check("flush_busy_c11", busy, 0);
      check("flush_no_ack", seen, 0);
      check("flush_hilo_kept", {hi, lo}, {32'd1, 32'd0});
      // Flush in IDLE with the request still pending: no grant
      cyc();
      check("flush_idle_no_grant", busy, 0);
      flush = 1'b0;
      run_op(0, MD_OP_MULT, 32'd3, 32'd5, n);
      check("post_flush_ack_cycle", n, 33);
      cyc();
      check("post_flush_hilo", {hi, lo}, {32'd0, 32'd15});

      // Reset mid-DIV at cycle 20
      req1 = 1'b1; op1 = MD_OP_DIV; rs1 = 32'd100; rt1 = 32'd3;
      for (int c = 1; c <= 20; c++) cyc();
      rst = 1'b0;
      req1 = 1'b0;
      cyc();
      check("midrst_busy", busy, 0);
      check("midrst_acks", {ack0, ack1}, 0);
      check("midrst_hilo", {hi, lo}, 0);
      check("midrst_hilo_valid", hilo_valid, 1);
      rst = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         cyc();
         seen |= ack0 | ack1 | busy;
      end
      check("midrst_no_late_ack", seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
